// File: rtl/cci_mpf_svc_vtp_client_mux_pkg.sv
// Shared VTP lookup types plus the per-service-tag context record used by the
// N-client front end of the translation service.
package cci_mpf_svc_vtp_client_mux_pkg;

  localparam int CCI_MPF_SHIM_VTP_MAX_SVC_REQS = 16;

  localparam int VTP_VA_W     = 36;
  localparam int VTP_PA_W     = 26;
  localparam int VTP_TAG_W    = 4;
  localparam int CLIENT_IDX_W = 3;

  typedef logic [VTP_VA_W-1:0]  t_tlb_4k_va;
  typedef logic [VTP_PA_W-1:0]  t_tlb_4k_pa;
  typedef logic [VTP_TAG_W-1:0] t_cci_mpf_shim_vtp_tag;

  typedef struct packed {
    t_tlb_4k_va            pageVA;
    t_cci_mpf_shim_vtp_tag tag;
  } t_cci_mpf_shim_vtp_lookup_req;

  typedef struct packed {
    t_tlb_4k_pa            pagePA;
    t_cci_mpf_shim_vtp_tag tag;
    logic                  isBigPage;
  } t_cci_mpf_shim_vtp_lookup_rsp;

  // Who owns a service tag while it is in flight.
  typedef struct packed {
    logic [CLIENT_IDX_W-1:0] client;
    t_cci_mpf_shim_vtp_tag   clientTag;
  } t_cci_mpf_svc_vtp_ctx;

  // Client index k slots after base, wrapping at n.
  function automatic int rrIdx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo2.sv
// Two-entry FIFO with a registered not-full flag that already accounts for
// the enqueue/dequeue of the current cycle, so a producer gated by it can
// never overflow.
module cci_mpf_prim_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enqEn,
  input  logic [WIDTH-1:0] enqData,
  input  logic             deqEn,
  output logic [WIDTH-1:0] first,
  output logic             notEmpty,
  output logic             notFull
);

  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       cnt;
  logic [1:0]       cntNext;

  always_comb begin
    cntNext = cnt;
    unique case ({enqEn, deqEn})
      2'b10:   cntNext = cnt + 2'd1;
      2'b01:   cntNext = cnt - 2'd1;
      default: cntNext = cnt;
    endcase
  end

  assign first    = data0;
  assign notEmpty = (cnt != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data0   <= '0;
      data1   <= '0;
      cnt     <= 2'd0;
      notFull <= 1'b0;
    end else begin
      cnt     <= cntNext;
      notFull <= (cntNext < 2'd2);
      if (deqEn) data0 <= data1;
      // The enqueue lands in whichever slot is free after this cycle's dequeue.
      if (enqEn) begin
        if ((cnt == 2'd0) || ((cnt == 2'd1) && deqEn)) data0 <= enqData;
        else data1 <= enqData;
      end
    end
  end

endmodule

// File: rtl/cci_mpf_svc_vtp_client_mux.sv
// N-client front end for the shared VTP translation service: per-client
// request FIFOs, round-robin issue with service tags from a free list, and
// response routing back to the originating client with its tag restored.
module cci_mpf_svc_vtp_client_mux
  import cci_mpf_svc_vtp_client_mux_pkg::*;
#(
  parameter int N_CLIENTS  = 2,
  parameter int N_SVC_TAGS = CCI_MPF_SHIM_VTP_MAX_SVC_REQS
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic [N_CLIENTS-1:0]          cli_lookupEn,
  input  t_cci_mpf_shim_vtp_lookup_req  cli_lookupReq [N_CLIENTS],
  output logic [N_CLIENTS-1:0]          cli_lookupRdy,
  output logic [N_CLIENTS-1:0]          cli_lookupRspValid,
  output t_cci_mpf_shim_vtp_lookup_rsp  cli_lookupRsp [N_CLIENTS],

  output logic                          svc_lookupEn,
  output t_cci_mpf_shim_vtp_lookup_req  svc_lookupReq,
  input  logic                          svc_lookupRdy,
  input  logic                          svc_lookupRspValid,
  input  t_cci_mpf_shim_vtp_lookup_rsp  svc_lookupRsp,

  output logic                          errBadTag,
  output logic [$clog2(N_SVC_TAGS):0]   outstanding
);

  localparam int SVC_IDX_W = $clog2(N_SVC_TAGS);
  localparam int CLI_IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int OUT_W     = SVC_IDX_W + 1;

  // Handshakes: a request transfers on a cycle where En and Rdy are both high
  // (client side: Rdy registered; service side: svc_lookupRdy sampled this
  // cycle). Responses are single-cycle strobes with no back-pressure.

  t_cci_mpf_shim_vtp_lookup_req fifoFirst [N_CLIENTS];
  logic [N_CLIENTS-1:0]         fifoNotEmpty;
  logic [N_CLIENTS-1:0]         fifoDeq;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : gCli
    cci_mpf_prim_fifo2 #(
      .WIDTH($bits(t_cci_mpf_shim_vtp_lookup_req))
    ) fifo (
      .clk      (clk),
      .reset    (reset),
      .enqEn    (cli_lookupEn[i] & cli_lookupRdy[i]),
      .enqData  (cli_lookupReq[i]),
      .deqEn    (fifoDeq[i]),
      .first    (fifoFirst[i]),
      .notEmpty (fifoNotEmpty[i]),
      .notFull  (cli_lookupRdy[i])
    );
  end

  logic [N_SVC_TAGS-1:0]  freeVec;
  t_cci_mpf_svc_vtp_ctx   ctx [N_SVC_TAGS];
  logic [CLI_IDX_W-1:0]   rrPtr;

  // Round-robin grant starting at rrPtr.
  logic                 grantValid;
  logic [CLI_IDX_W-1:0] grantIdx;
  logic [CLI_IDX_W-1:0] cand;

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      cand = CLI_IDX_W'(rrIdx(int'(rrPtr), k, N_CLIENTS));
      if (!grantValid && fifoNotEmpty[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Lowest-index free service tag.
  logic                 tagAvail;
  logic [SVC_IDX_W-1:0] freeIdx;

  always_comb begin
    freeIdx = '0;
    for (int t = N_SVC_TAGS - 1; t >= 0; t--) begin
      if (freeVec[t]) freeIdx = SVC_IDX_W'(t);
    end
  end

  assign tagAvail = |freeVec;

  logic issue;
  assign issue = grantValid && svc_lookupRdy && tagAvail;

  assign svc_lookupEn         = issue;
  assign svc_lookupReq.pageVA = fifoFirst[grantIdx].pageVA;
  assign svc_lookupReq.tag    = VTP_TAG_W'(freeIdx);

  for (genvar i = 0; i < N_CLIENTS; i++) begin : gDeq
    assign fifoDeq[i] = issue && (grantIdx == CLI_IDX_W'(i));
  end

  // A response is valid only for an in-range tag that is currently in use.
  logic                 rspInRange;
  logic [SVC_IDX_W-1:0] rspTag;
  logic                 rspGood;
  logic                 rspBad;
  t_cci_mpf_svc_vtp_ctx rspCtx;

  assign rspInRange = ({1'b0, svc_lookupRsp.tag} < (VTP_TAG_W + 1)'(N_SVC_TAGS));
  assign rspTag     = svc_lookupRsp.tag[SVC_IDX_W-1:0];
  assign rspGood    = svc_lookupRspValid && rspInRange && !freeVec[rspTag];
  assign rspBad     = svc_lookupRspValid && !rspGood;
  assign rspCtx     = ctx[rspTag];

  logic [N_SVC_TAGS-1:0] issueMask;
  logic [N_SVC_TAGS-1:0] freeMask;

  always_comb begin
    issueMask = '0;
    freeMask  = '0;
    if (issue)   issueMask[freeIdx] = 1'b1;
    if (rspGood) freeMask[rspTag]   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeVec            <= '1;
      rrPtr              <= '0;
      outstanding        <= '0;
      errBadTag          <= 1'b0;
      cli_lookupRspValid <= '0;
      for (int i = 0; i < N_CLIENTS; i++) cli_lookupRsp[i] <= '0;
      for (int t = 0; t < N_SVC_TAGS; t++) ctx[t] <= '0;
    end else begin
      // Issue takes a free tag and a response frees a busy one, so the two
      // masks never overlap and a just-freed tag is only usable next cycle.
      freeVec <= (freeVec & ~issueMask) | freeMask;

      if (issue) begin
        ctx[freeIdx] <= '{client: CLIENT_IDX_W'(grantIdx),
                          clientTag: fifoFirst[grantIdx].tag};
        rrPtr        <= CLI_IDX_W'(rrIdx(int'(grantIdx), 1, N_CLIENTS));
      end

      unique case ({issue, rspGood})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (rspBad) errBadTag <= 1'b1;

      cli_lookupRspValid <= '0;
      if (rspGood) begin
        for (int i = 0; i < N_CLIENTS; i++) begin
          if (rspCtx.client == CLIENT_IDX_W'(i)) begin
            cli_lookupRspValid[i] <= 1'b1;
            cli_lookupRsp[i]      <= '{pagePA: svc_lookupRsp.pagePA,
                                       tag: rspCtx.clientTag,
                                       isBigPage: svc_lookupRsp.isBigPage};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_svc_vtp_client_mux.sv
// Directed bench for the VTP client mux: single-client round trip, two-client
// alternation with out-of-order responses, tag exhaustion, bad tags and reset.
module tb_cci_mpf_svc_vtp_client_mux;
  import cci_mpf_svc_vtp_client_mux_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [1:0]                   cli_lookupEn;
  t_cci_mpf_shim_vtp_lookup_req cli_lookupReq [2];
  logic [1:0]                   cli_lookupRdy;
  logic [1:0]                   cli_lookupRspValid;
  t_cci_mpf_shim_vtp_lookup_rsp cli_lookupRsp [2];
  logic                         svc_lookupEn;
  t_cci_mpf_shim_vtp_lookup_req svc_lookupReq;
  logic                         svc_lookupRdy;
  logic                         svc_lookupRspValid;
  t_cci_mpf_shim_vtp_lookup_rsp svc_lookupRsp;
  logic                         errBadTag;
  logic [4:0]                   outstanding;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  cci_mpf_svc_vtp_client_mux #(.N_CLIENTS(2), .N_SVC_TAGS(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .cli_lookupEn       (cli_lookupEn),
    .cli_lookupReq      (cli_lookupReq),
    .cli_lookupRdy      (cli_lookupRdy),
    .cli_lookupRspValid (cli_lookupRspValid),
    .cli_lookupRsp      (cli_lookupRsp),
    .svc_lookupEn       (svc_lookupEn),
    .svc_lookupReq      (svc_lookupReq),
    .svc_lookupRdy      (svc_lookupRdy),
    .svc_lookupRspValid (svc_lookupRspValid),
    .svc_lookupRsp      (svc_lookupRsp),
    .errBadTag          (errBadTag),
    .outstanding        (outstanding)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic send_rsp(input int tag, input int pa, input logic big);
    svc_lookupRspValid = 1'b1;
    svc_lookupRsp      = '{pagePA: 26'(pa), tag: 4'(tag), isBigPage: big};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int order   [4] = '{3, 0, 2, 1};
  int expCli  [4] = '{1, 0, 0, 1};
  int issued;
  int pushCnt [2];
  logic [3:0] expTag;

  initial begin
    reset              = 1'b1;
    cli_lookupEn       = 2'b00;
    cli_lookupReq[0]   = '0;
    cli_lookupReq[1]   = '0;
    svc_lookupRdy      = 1'b1;
    svc_lookupRspValid = 1'b0;
    svc_lookupRsp      = '0;
    #2;

    // Reset state
    chk("reset_rdy",      64'(cli_lookupRdy), 64'(0));
    chk("reset_svcEn",    64'(svc_lookupEn), 64'(0));
    chk("reset_outst",    64'(outstanding), 64'(0));
    chk("reset_err",      64'(errBadTag), 64'(0));
    chk("reset_rspValid", 64'(cli_lookupRspValid), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    chk("rdy_before_first_clock", 64'(cli_lookupRdy), 64'(0));
    tick();
    chk("rdy_after_release", 64'(cli_lookupRdy), 64'(2'b11));

    // Single client round trip
    cli_lookupEn     = 2'b01;
    cli_lookupReq[0] = '{pageVA: 36'h123456789, tag: 4'd5};
    #1;
    chk("t1_no_issue_same_cycle", 64'(svc_lookupEn), 64'(0));
    tick();
    cli_lookupEn = 2'b00;
    chk("t1_svcEn",  64'(svc_lookupEn), 64'(1));
    chk("t1_svcVA",  64'(svc_lookupReq.pageVA), 64'h123456789);
    chk("t1_svcTag", 64'(svc_lookupReq.tag), 64'(0));
    tick();
    chk("t1_outst_1",   64'(outstanding), 64'(1));
    chk("t1_svcEn_off", 64'(svc_lookupEn), 64'(0));
    send_rsp(0, 26'h2ABCDE, 1'b1);
    tick();
    svc_lookupRspValid = 1'b0;
    chk("t1_rspValid", 64'(cli_lookupRspValid), 64'(2'b01));
    chk("t1_rspPA",    64'(cli_lookupRsp[0].pagePA), 64'h2ABCDE);
    chk("t1_rspTag",   64'(cli_lookupRsp[0].tag), 64'(5));
    chk("t1_rspBig",   64'(cli_lookupRsp[0].isBigPage), 64'(1));
    chk("t1_outst_0",  64'(outstanding), 64'(0));
    tick();
    chk("t1_rspValid_pulse", 64'(cli_lookupRspValid), 64'(0));

    // Two clients, identical client tags, alternating grants
    do_reset();
    cli_lookupEn     = 2'b11;
    cli_lookupReq[0] = '{pageVA: 36'h1000, tag: 4'd3};
    cli_lookupReq[1] = '{pageVA: 36'h2000, tag: 4'd3};
    tick();
    cli_lookupReq[0] = '{pageVA: 36'h1001, tag: 4'd3};
    cli_lookupReq[1] = '{pageVA: 36'h2001, tag: 4'd3};
    chk("t2_g0_en",  64'(svc_lookupEn), 64'(1));
    chk("t2_g0_va",  64'(svc_lookupReq.pageVA), 64'h1000);
    chk("t2_g0_tag", 64'(svc_lookupReq.tag), 64'(0));
    tick();
    cli_lookupEn = 2'b00;
    chk("t2_rdy_c1_full", 64'(cli_lookupRdy), 64'(2'b01));
    chk("t2_g1_va",  64'(svc_lookupReq.pageVA), 64'h2000);
    chk("t2_g1_tag", 64'(svc_lookupReq.tag), 64'(1));
    tick();
    chk("t2_rdy_back", 64'(cli_lookupRdy), 64'(2'b11));
    chk("t2_g2_va",  64'(svc_lookupReq.pageVA), 64'h1001);
    chk("t2_g2_tag", 64'(svc_lookupReq.tag), 64'(2));
    tick();
    chk("t2_g3_va",  64'(svc_lookupReq.pageVA), 64'h2001);
    chk("t2_g3_tag", 64'(svc_lookupReq.tag), 64'(3));
    tick();
    chk("t2_idle",  64'(svc_lookupEn), 64'(0));
    chk("t2_outst", 64'(outstanding), 64'(4));
    for (int k = 0; k < 4; k++) begin
      send_rsp(order[k], 256 + order[k], 1'b0);
      tick();
      svc_lookupRspValid = 1'b0;
      chk("t2_rsp_valid", 64'(cli_lookupRspValid), 64'(2'b01) << expCli[k]);
      chk("t2_rsp_tag",   64'(cli_lookupRsp[expCli[k]].tag), 64'(3));
      chk("t2_rsp_pa",    64'(cli_lookupRsp[expCli[k]].pagePA), 64'(256 + order[k]));
    end
    chk("t2_outst_0", 64'(outstanding), 64'(0));

    // Bad tag
    send_rsp(9, 26'h999, 1'b0);
    tick();
    svc_lookupRspValid = 1'b0;
    chk("t5_err_set",   64'(errBadTag), 64'(1));
    chk("t5_no_rsp",    64'(cli_lookupRspValid), 64'(0));
    chk("t5_outst",     64'(outstanding), 64'(0));
    tick();
    chk("t5_err_sticky", 64'(errBadTag), 64'(1));

    // Tag exhaustion: service never responds
    for (int t = 0; t < 16; t++) exp_q.push_back(4'(t));
    issued     = 0;
    pushCnt[0] = 0;
    pushCnt[1] = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      cli_lookupEn     = cli_lookupRdy;
      cli_lookupReq[0] = '{pageVA: 36'(cyc), tag: 4'(pushCnt[0])};
      cli_lookupReq[1] = '{pageVA: 36'(2048 + cyc), tag: 4'(pushCnt[1])};
      if (svc_lookupEn) begin
        issued++;
        if (exp_q.size() == 0) begin
          chk("t3_extra_issue", 64'(issued), 64'(16));
        end else begin
          expTag = exp_q.pop_front();
          chk("t3_issue_tag", 64'(svc_lookupReq.tag), 64'(expTag));
        end
      end
      if (cli_lookupRdy[0]) pushCnt[0]++;
      if (cli_lookupRdy[1]) pushCnt[1]++;
      tick();
    end
    cli_lookupEn = 2'b00;
    chk("t3_issued",   64'(issued), 64'(16));
    chk("t3_stalled",  64'(svc_lookupEn), 64'(0));
    chk("t3_outst",    64'(outstanding), 64'(16));
    chk("t3_rdy_low",  64'(cli_lookupRdy), 64'(0));
    chk("t3_pushes0",  64'(pushCnt[0]), 64'(10));
    chk("t3_pushes1",  64'(pushCnt[1]), 64'(10));

    // Response tag 7 with a pending request: freed tag usable next cycle
    send_rsp(7, 26'h77, 1'b1);
    #1;
    chk("t4_blocked_7", 64'(svc_lookupEn), 64'(0));
    tick();
    svc_lookupRspValid = 1'b0;
    chk("t4_rsp7_valid", 64'(cli_lookupRspValid), 64'(2'b10));
    chk("t4_rsp7_tag",   64'(cli_lookupRsp[1].tag), 64'(3));
    chk("t4_rsp7_big",   64'(cli_lookupRsp[1].isBigPage), 64'(1));
    chk("t4_reissue7_en",  64'(svc_lookupEn), 64'(1));
    chk("t4_reissue7_tag", 64'(svc_lookupReq.tag), 64'(7));
    chk("t4_outst_15",   64'(outstanding), 64'(15));
    tick();
    chk("t4_outst_16",   64'(outstanding), 64'(16));
    chk("t4_stall_again", 64'(svc_lookupEn), 64'(0));
    send_rsp(4, 26'h44, 1'b0);
    #1;
    chk("t4_blocked_4", 64'(svc_lookupEn), 64'(0));
    tick();
    svc_lookupRspValid = 1'b0;
    chk("t4_rsp4_valid", 64'(cli_lookupRspValid), 64'(2'b01));
    chk("t4_rsp4_tag",   64'(cli_lookupRsp[0].tag), 64'(2));
    chk("t4_rsp4_pa",    64'(cli_lookupRsp[0].pagePA), 64'h44);
    chk("t4_reissue4_en",  64'(svc_lookupEn), 64'(1));
    chk("t4_reissue4_tag", 64'(svc_lookupReq.tag), 64'(4));
    tick();

    // Asynchronous reset with 10 tags outstanding
    do_reset();
    for (int k = 0; k < 11; k++) begin
      cli_lookupEn     = 2'b01;
      cli_lookupReq[0] = '{pageVA: 36'(k), tag: 4'(k)};
      tick();
    end
    cli_lookupEn = 2'b00;
    chk("t6_rdy_sustain", 64'(cli_lookupRdy), 64'(2'b11));
    chk("t6_outst_10",    64'(outstanding), 64'(10));
    chk("t6_pending_en",  64'(svc_lookupEn), 64'(1));
    chk("t6_pending_tag", 64'(svc_lookupReq.tag), 64'(10));
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_rdy",   64'(cli_lookupRdy), 64'(0));
    chk("t6_async_svcEn", 64'(svc_lookupEn), 64'(0));
    chk("t6_async_outst", 64'(outstanding), 64'(0));
    chk("t6_async_err",   64'(errBadTag), 64'(0));
    chk("t6_async_rspV",  64'(cli_lookupRspValid), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    chk("t6_rdy_release", 64'(cli_lookupRdy), 64'(2'b11));
    chk("t6_outst_rel",   64'(outstanding), 64'(0));
    cli_lookupEn     = 2'b01;
    cli_lookupReq[0] = '{pageVA: 36'hABC, tag: 4'd1};
    tick();
    cli_lookupEn = 2'b00;
    chk("t6_first_en",  64'(svc_lookupEn), 64'(1));
    chk("t6_first_tag", 64'(svc_lookupReq.tag), 64'(0));
    chk("t6_first_va",  64'(svc_lookupReq.pageVA), 64'hABC);
    tick();
    chk("t6_outst_1",   64'(outstanding), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_svc_vtp_client_mux.md
# cci_mpf_svc_vtp_client_mux

Parametrised N-client front end for the shared VTP translation service. It lets `N_CLIENTS` VTP pipeline shims share one `cci_mpf_shim_vtp_svc_if` server port. Client tags are remapped to service tags drawn from a free list, and out-of-order responses are routed back to the originating client with its original tag restored. It sits between the per-pipeline VTP shims and the single translation service instance.

## Interface
Parameters:
- `N_CLIENTS`, default 2: number of client shims (1..8).
- `N_SVC_TAGS`, default `CCI_MPF_SHIM_VTP_MAX_SVC_REQS` (16): service-side tag space; power of 2.

Ports. Reset is asynchronous and active-high; there is a single clock.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `cli_lookupEn`  in  N_CLIENTS  per-client request enable. A client may assert it only while its `cli_lookupRdy` is high.
- `cli_lookupReq`  in  N_CLIENTS x t_cci_mpf_shim_vtp_lookup_req  per-client page VA (4KB index, 36b) and client tag (4b).
- `cli_lookupRdy`  out  N_CLIENTS  per-client ready; registered.
- `cli_lookupRspValid`  out  N_CLIENTS  one-cycle response strobe.
- `cli_lookupRsp`  out  N_CLIENTS x t_cci_mpf_shim_vtp_lookup_rsp  pagePA (26b), client tag, isBigPage.
- `svc_lookupEn`  out  1  request to the service.
- `svc_lookupReq`  out  t_cci_mpf_shim_vtp_lookup_req  VA plus service tag.
- `svc_lookupRdy`  in  1  the service can accept a request this cycle.
- `svc_lookupRspValid`  in  1  service response strobe.
- `svc_lookupRsp`  in  t_cci_mpf_shim_vtp_lookup_rsp  response carrying a service tag.
- `errBadTag`  out  1  sticky: a response arrived for a service tag not in use.
- `outstanding`  out  $clog2(N_SVC_TAGS)+1  count of in-flight service tags.

## Operation
- Each client has a 2-entry request FIFO. `cli_lookupRdy[i] = (occupancy_q[i] < 2)`, registered. An En while Rdy is high always pushes; overflow is impossible by construction.
- Arbiter: round-robin over clients with a non-empty FIFO.
  - It issues when `svc_lookupRdy && tagAvail`, with `tagAvail = |freeVec`.
  - The pointer moves to grantee+1 mod N_CLIENTS after each grant and holds when there is no grant.
- Issue, combinational in the grant cycle:
  - `svc_lookupEn = 1`.
  - `svc_lookupReq.pageVA` = head VA of the granted client.
  - `svc_lookupReq.tag` = lowest-index set bit of `freeVec`.
  - At the clock edge: clear that `freeVec` bit, write `ctx[tag] = {client idx, client tag}`, pop the FIFO.
- Response: on `svc_lookupRspValid` with `freeVec[tag] == 0`, read `ctx[tag]`. On the next cycle:
  - assert `cli_lookupRspValid[ctx.client]` only;
  - drive that client's `cli_lookupRsp` with `{pagePA, ctx.clientTag, isBigPage}`.
  - `freeVec[tag]` is set at the same edge.
- Bad tag (response tag already free): set `errBadTag`, emit no client response, leave `freeVec` unchanged.
- `outstanding` = N_SVC_TAGS − popcount(freeVec), tracked as a registered counter: +1 on issue, −1 on valid free; both in one cycle leaves it unchanged.
- Client tag uniqueness within a client is the client's responsibility. Different clients may use identical tags.

## Timing
- Request latency: En at cycle t → earliest `svc_lookupEn` at t+1.
- Response latency: `svc_lookupRspValid` at t → `cli_lookupRspValid` at t+1.
- Sustained throughput: one issue per cycle in aggregate. A single client alone sustains one request per cycle; its occupancy holds at 1.
- All tags in use: no issue. FIFOs fill and Rdy drops the cycle after occupancy reaches 2.
- Response and request in the same cycle with `freeVec` all zero: the freed tag is not usable in that cycle. It is issued at the earliest on the next cycle.
- Reset, asynchronous and effective immediately, including mid-operation:
  - outputs: `cli_lookupRdy` 0, `cli_lookupRspValid` 0, `svc_lookupEn` 0, `errBadTag` 0, `outstanding` 0;
  - state: `freeVec` all 1, FIFOs empty, RR pointer 0.
  - `cli_lookupRdy` returns to all 1 on the first clock after release.
  - In-flight service responses arriving after reset are bad tags only if their tag is free, which it is, so `errBadTag` flags them. The integration must reset the service together with this block.

## Structure
- Shared VTP header (existing): `t_cci_mpf_shim_vtp_lookup_req/rsp`, `CCI_MPF_SHIM_VTP_MAX_SVC_REQS`. Add `t_cci_mpf_svc_vtp_ctx` (client idx, client tag) there.
- Sub-module: `cci_mpf_prim_fifo2` (2-entry FIFO, async reset), one instance per client.
- `ctx` is a N_SVC_TAGS-entry register array, written on issue and read on response.

## Test plan
- One client, tag 5, VA 0x123456789 → `svc_lookupEn` next cycle with svc tag 0. Response {tag 0, PA 0x2ABCDE, big 1} → next cycle `cli_lookupRspValid[0]` with tag 5, PA 0x2ABCDE, isBigPage 1, and `outstanding` back to 0.
- Two clients requesting every cycle, both with tag 3 → grants alternate 0,1,0,1 on svc tags 0,1,2,3. Responses returned in order 3,0,2,1 → each reaches the correct client with tag 3 and the matching PA.
- Service never responds → 16 issues, then `svc_lookupEn` stays 0, `outstanding` = 16, each client's Rdy drops after 2 further pushes. One response (tag 7) → tag 7 is reissued the next cycle.
- All tags full, response on tag 4 and a pending request in the same cycle → no issue that cycle; issue with tag 4 on the following cycle.
- Response with an unused tag 9 → `errBadTag` = 1 and stays set, no `cli_lookupRspValid`, `outstanding` unchanged.
- Reset asserted asynchronously with 10 tags outstanding → all outputs 0 immediately. After release: Rdy all 1, the first request gets svc tag 0, `outstanding` = 0.
